// File: rtl/apb_uart_rx_pkg.sv
// Shared definitions for the APB UART receiver: receiver FSM states,
// register offsets and STATUS bit positions.
package apb_uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    localparam logic [1:0] UART_RX_DATA   = 2'd0;
    localparam logic [1:0] UART_RX_STATUS = 2'd1;
    localparam logic [1:0] UART_RX_CLEAR  = 2'd2;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FERR      = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO of 2^ADDR_EXP entries; push and pop may share a cycle,
// including a push into a full FIFO that is being popped at the same time.
module uart_rx_fifo #(
    parameter int ADDR_EXP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    output logic [7:0]        dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_EXP:0] count
);

    localparam int DEPTH = 1 << ADDR_EXP;

    logic [7:0]          mem [DEPTH];
    logic [ADDR_EXP-1:0] wr_ptr;
    logic [ADDR_EXP-1:0] rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_EXP'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_EXP'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (ADDR_EXP+1)'(1);
                2'b01:   count <= count - (ADDR_EXP+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr; the head is read combinationally
    // before the edge that overwrites it.
    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (ADDR_EXP+1)'(DEPTH));

endmodule

// File: rtl/apb_uart_rx.sv
// APB slave UART receiver: 8N1 deserialiser feeding a byte FIFO, with
// DATA / STATUS / CLEAR registers and zero-wait-state access.
module apb_uart_rx
    import apb_uart_rx_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_EXP     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    input  logic                  rx_wire
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta;
    logic              rx_s;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              line_high_q, line_high_d;
    logic              push_req;
    logic              ferr_set;
    logic              frame_err;
    logic              overrun;

    logic              access;
    logic              rd_access;
    logic              wr_access;
    logic [1:0]        addr;
    logic              pop_req;
    logic              clr_req;
    logic              ovr_set;
    logic [7:0]        fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_EXP:0] fifo_count;
    logic              unused_bus;

    assign unused_bus = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:2]};

    // Input synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_wire;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            line_high_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            line_high_q <= line_high_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    // A new start needs a high-to-low edge, so a held break reports only once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        line_high_d = line_high_q;
        push_req    = 1'b0;
        ferr_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    line_high_d = 1'b1;
                end else if (line_high_q) begin
                    state_d     = ST_START;
                    bit_d       = '0;
                    line_high_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                    line_high_d = rx_s;
                    push_req    = rx_s;
                    ferr_set    = ~rx_s;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign access    = S_PSELx & S_PENABLE;
    assign rd_access = access & ~S_PWRITE;
    assign wr_access = access & S_PWRITE;
    assign addr      = S_PADDR[1:0];
    assign pop_req   = rd_access & (addr == UART_RX_DATA) & ~fifo_empty;
    assign clr_req   = wr_access & (addr == UART_RX_CLEAR);
    assign ovr_set   = push_req & fifo_full & ~pop_req;
    assign S_PREADY  = access;

    uart_rx_fifo #(
        .ADDR_EXP (ADDR_EXP)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (shreg_q),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set | (frame_err & ~(clr_req & S_PWDATA[0]));
            overrun   <= ovr_set  | (overrun   & ~(clr_req & S_PWDATA[1]));
        end
    end

    always_comb begin
        S_PRDATA = '0;
        if (rd_access) begin
            case (addr)
                UART_RX_DATA: begin
                    if (!fifo_empty) begin
                        S_PRDATA[7:0] = fifo_dout;
                    end
                end
                UART_RX_STATUS: begin
                    S_PRDATA[STAT_EMPTY]                    = fifo_empty;
                    S_PRDATA[STAT_FULL]                     = fifo_full;
                    S_PRDATA[STAT_FERR]                     = frame_err;
                    S_PRDATA[STAT_OVERRUN]                  = overrun;
                    S_PRDATA[STAT_COUNT_LSB +: ADDR_EXP+1]  = fifo_count;
                end
                default: S_PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_rx.sv
// Bench for apb_uart_rx: frames and APB accesses are issued by the stimulus
// process, expected read data is queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_apb_uart_rx;

    localparam int CPB   = 8;
    localparam int AE    = 4;
    localparam int BW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AE;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] paddr = '0;
    logic          pwrite = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          rx_wire = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [7:0]    model_q[$];
    bit            m_ferr = 1'b0;
    bit            m_ovr  = 1'b0;

    apb_uart_rx #(
        .BUS_WIDTH    (BW),
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .ADDR_EXP     (AE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
        .rx_wire   (rx_wire)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: run exceeded its time limit");
        $fatal(1, "timeout");
    end

    // Monitor: every cycle, checks the APB outputs against the scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        vectors++;
        if (psel && penable) begin
            if (pready !== 1'b1) begin
                miscompares++;
                $display("FAIL pready_access: actual=%b required=1", pready);
            end
            if (!pwrite) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: actual=%h required=<no read pending>", prdata);
                end else begin
                    e = exp_q.pop_front();
                    if (prdata !== e) begin
                        miscompares++;
                        $display("FAIL rd_data addr=%0d: actual=%h required=%h", paddr[1:0], prdata, e);
                    end
                end
            end else if (prdata !== '0) begin
                vectors++;
                miscompares++;
                $display("FAIL prdata_write: actual=%h required=0", prdata);
            end
        end else if (pready !== 1'b0 || prdata !== '0) begin
            miscompares++;
            $display("FAIL idle_outputs: actual pready=%b prdata=%h required pready=0 prdata=0", pready, prdata);
        end
    end

    function automatic logic [DW-1:0] model_status();
        int n = model_q.size();
        return DW'(n * 256 + int'(m_ovr) * 8 + int'(m_ferr) * 4
                   + int'(n == DEPTH) * 2 + int'(n == 0));
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit stop);
        if (!stop) m_ferr = 1'b1;
        else if (model_q.size() == DEPTH) m_ovr = 1'b1;
        else model_q.push_back(b);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_read(input logic [1:0] a);
        logic [DW-1:0] e;
        e = '0;
        if (a == 2'd0) begin
            if (model_q.size() > 0) e = DW'(model_q.pop_front());
        end else if (a == 2'd1) begin
            e = model_status();
        end
        exp_q.push_back(e);
        paddr = BW'($urandom);
        paddr[1:0] = a;
        pwrite = 1'b0;
        psel = 1'b1;
        penable = 1'b0;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [DW-1:0] d);
        if (a == 2'd2) begin
            if (d[0]) m_ferr = 1'b0;
            if (d[1]) m_ovr = 1'b0;
        end
        paddr = BW'($urandom);
        paddr[1:0] = a;
        pwdata = d;
        pwrite = 1'b1;
        psel = 1'b1;
        penable = 1'b0;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit stop);
        rx_wire = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_wire = b[i];
            tick(CPB);
        end
        rx_wire = stop;
        tick(CPB);
        rx_wire = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        send_raw(b, stop);
        model_frame(b, stop);
        tick(4);
    endtask

    initial begin
        logic [7:0] b;
        tick(3);
        reset = 1'b0;
        tick(3);
        apb_read(2'd1);

        // Single byte, then drain.
        send_frame(8'hA5, 1'b1);
        apb_read(2'd1);
        apb_read(2'd0);
        apb_read(2'd1);

        // Short low glitch while idle.
        rx_wire = 1'b0;
        tick(3);
        rx_wire = 1'b1;
        tick(20);
        apb_read(2'd1);

        // Bad stop bit, then clear the frame error.
        send_frame(8'h3C, 1'b0);
        apb_read(2'd1);
        apb_write(2'd2, 16'h0001);
        apb_read(2'd1);

        // Break: held low for longer than a frame reports one frame error.
        rx_wire = 1'b0;
        tick(12 * CPB);
        rx_wire = 1'b1;
        m_ferr = 1'b1;
        tick(100);
        apb_read(2'd1);
        apb_write(2'd2, 16'h0001);

        // Seventeen bytes into a sixteen-entry FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        apb_read(2'd1);
        for (int i = 0; i < 17; i++) apb_read(2'd0);
        apb_read(2'd1);
        apb_write(2'd0, 16'hFFFF);
        apb_write(2'd1, 16'hFFFF);
        apb_write(2'd3, 16'hFFFF);
        apb_read(2'd2);
        apb_read(2'd3);
        apb_write(2'd2, 16'h0002);
        apb_read(2'd1);

        // Fill, then pop in the same cycle as the stop-bit push.
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1);
        b = 8'($urandom);
        fork
            send_raw(b, 1'b1);
            begin
                tick(77);
                apb_read(2'd0);
            end
        join
        model_q.push_back(b);
        tick(4);
        apb_read(2'd1);
        for (int i = 0; i < DEPTH; i++) apb_read(2'd0);
        apb_read(2'd1);

        // Randomised traffic.
        for (int f = 0; f < 60; f++) begin
            send_frame(8'($urandom), $urandom_range(0, 9) != 0);
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 3) == 0)
                    apb_write(2'($urandom_range(0, 3)), DW'($urandom));
                else
                    apb_read(2'($urandom_range(0, 3)));
            end
        end
        apb_read(2'd1);

        // Reset in the middle of data bit 4 flushes everything.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b0);
        rx_wire = 1'b0;
        tick(CPB);
        b = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            rx_wire = b[i];
            tick(CPB);
        end
        rx_wire = b[4];
        tick(3);
        reset = 1'b1;
        rx_wire = 1'b1;
        model_q.delete();
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        apb_read(2'd1);
        send_frame(8'h5A, 1'b1);
        apb_read(2'd1);
        apb_read(2'd0);
        apb_read(2'd1);

        tick(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_reads: actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
